// File: rtl/replica_pkg.sv
// Shared types and default sizes for the replica route memory.
// route_cmd_t selects the write-bank source; route_state_t is the control FSM.
package replica_pkg;

    localparam int CITY_NUM_DEF = 64;
    localparam int DATA_W_DEF   = 8;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        PREV = 3'd1,
        FOLW = 3'd2,
        SELF = 3'd3,
        HOST = 3'd4
    } route_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } route_state_t;

endpackage

// File: rtl/route_addr_gen.sv
// Read-address generator: logical position counter, 2-opt mirror mapping
// and credit tracking for the 2-entry output skid.
// Ports: start/active control, pop (output handshake), latched opt fields,
// issue/last_issue strobes, raddr (physical address), drained (pipe empty).
module route_addr_gen #(
    parameter int CITY_NUM = 64,
    parameter int AW       = $clog2(CITY_NUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          active,
    input  logic          pop,
    input  logic          opt_en,
    input  logic [AW-1:0] opt_lo,
    input  logic [AW-1:0] opt_hi,
    output logic          issue,
    output logic          last_issue,
    output logic [AW-1:0] raddr,
    output logic          drained
);

    logic [AW-1:0] p;
    logic [1:0]    outstanding;
    logic [AW:0]   mirror;
    logic          in_seg;

    // outstanding = words in the RAM read stage plus words held in the skid
    assign issue      = active && ((outstanding != 2'd2) || pop);
    assign last_issue = issue && (p == AW'(CITY_NUM - 1));
    assign drained    = (outstanding == 2'd0) ||
                        ((outstanding == 2'd1) && pop);

    assign mirror = {1'b0, opt_lo} + {1'b0, opt_hi} - {1'b0, p};
    assign in_seg = opt_en && (p >= opt_lo) && (p <= opt_hi);
    assign raddr  = in_seg ? mirror[AW-1:0] : p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p <= '0;
        end else if (start) begin
            p <= '0;
        end else if (issue) begin
            p <= last_issue ? '0 : p + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= 2'd0;
        end else begin
            outstanding <= outstanding + {1'b0, issue} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/replica_route_ram.sv
// Double-banked route memory for one parallel-tempering replica.
// Streams the read bank (optionally 2-opt reversed) and fills the other
// bank from prev/folw/self/host. Ports: cmd handshake + opt fields, swap,
// rbank, three source streams, ready/valid route output, busy/wr_done/err.
module replica_route_ram
    import replica_pkg::*;
#(
    parameter int CITY_NUM = CITY_NUM_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AW       = $clog2(CITY_NUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  route_cmd_t        cmd,
    input  logic              opt_en,
    input  logic [AW-1:0]     opt_lo,
    input  logic [AW-1:0]     opt_hi,
    input  logic              swap,
    output logic              rbank,
    input  logic              prev_valid,
    input  logic [DATA_W-1:0] prev_data,
    input  logic              folw_valid,
    input  logic [DATA_W-1:0] folw_data,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              wr_done,
    output logic              err
);

    route_state_t      state, state_nxt;
    route_cmd_t        cmd_q;
    logic              oe_q;
    logic [AW-1:0]     lo_q, hi_q;
    logic [AW-1:0]     wcount;
    logic              accept, swap_ok, lo_gt_hi;
    logic              active, streaming;
    logic              src_v;
    logic [DATA_W-1:0] src_d;
    logic              wr_en, wr_last;
    logic              issue, last_issue, drained;
    logic [AW-1:0]     raddr;
    logic              wbank;
    logic              pop, rd_v;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] ram_q, q0, q1;

    logic [DATA_W-1:0] mem [2][CITY_NUM];

    assign accept   = cmd_valid && cmd_ready && (cmd != NOP);
    assign swap_ok  = swap && (state == IDLE) && wr_done;
    assign lo_gt_hi = opt_lo > opt_hi;
    assign wbank    = ~rbank;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = STREAM;
            STREAM:  if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drained && (wr_done || wr_last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        active    = (state != IDLE);
        streaming = (state == STREAM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q <= NOP;
            oe_q  <= 1'b0;
            lo_q  <= '0;
            hi_q  <= '0;
        end else if (accept) begin
            cmd_q <= cmd;
            oe_q  <= opt_en && !lo_gt_hi;
            lo_q  <= opt_lo;
            hi_q  <= opt_hi;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbank   <= 1'b0;
            wr_done <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (swap_ok) rbank <= ~rbank;
            if (swap_ok || accept) begin
                wr_done <= 1'b0;
            end else if (wr_last) begin
                wr_done <= 1'b1;
            end
            if ((swap && !swap_ok) ||
                (cmd_valid && (cmd != NOP) && busy) ||
                (accept && opt_en && lo_gt_hi)) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        src_v = 1'b0;
        src_d = '0;
        unique case (1'b1)
            cmd_q == PREV: begin src_v = prev_valid; src_d = prev_data; end
            cmd_q == FOLW: begin src_v = folw_valid; src_d = folw_data; end
            cmd_q == SELF: begin src_v = pop;        src_d = out_data;  end
            cmd_q == HOST: begin src_v = host_valid; src_d = host_data; end
            default: ;
        endcase
    end

    // once the write bank is full, the rest of the source stream is dropped
    assign wr_en   = active && !wr_done && src_v;
    assign wr_last = wr_en && (wcount == AW'(CITY_NUM - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcount <= '0;
        end else if (accept) begin
            wcount <= '0;
        end else if (wr_en) begin
            wcount <= wr_last ? '0 : wcount + AW'(1);
        end
    end

    route_addr_gen #(
        .CITY_NUM (CITY_NUM),
        .AW       (AW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .start      (accept),
        .active     (streaming),
        .pop        (pop),
        .opt_en     (oe_q),
        .opt_lo     (lo_q),
        .opt_hi     (hi_q),
        .issue      (issue),
        .last_issue (last_issue),
        .raddr      (raddr),
        .drained    (drained)
    );

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wbank][wcount] <= src_d;
        if (issue) ram_q <= mem[rbank][raddr];
    end

    // 2-entry skid: q0 is the head and drives out_data directly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_v <= 1'b0;
            cnt  <= 2'd0;
            q0   <= '0;
            q1   <= '0;
        end else begin
            rd_v <= issue;
            case ({rd_v, pop})
                2'b10: begin
                    if (cnt == 2'd0) q0 <= ram_q;
                    else             q1 <= ram_q;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    q0  <= q1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        q0 <= q1;
                        q1 <= ram_q;
                    end else begin
                        q0 <= ram_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (cnt != 2'd0);
    assign out_data  = q0;

endmodule

// File: tb/tb_replica_route_ram.sv
// Scoreboard bench for replica_route_ram with CITY_NUM=8.
// A bank-level memory model predicts every streamed word and bank state.
module tb_replica_route_ram;
    import replica_pkg::*;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 3;

    typedef struct {
        logic [DW-1:0] d;
        bit            care;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    route_cmd_t    cmd;
    logic          opt_en;
    logic [AW-1:0] opt_lo, opt_hi;
    logic          swap;
    logic          rbank;
    logic          prev_valid, folw_valid, host_valid;
    logic [DW-1:0] prev_data, folw_data, host_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          busy, wr_done, err;

    always #5 clk = ~clk;

    replica_route_ram #(.CITY_NUM(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .opt_en     (opt_en),
        .opt_lo     (opt_lo),
        .opt_hi     (opt_hi),
        .swap       (swap),
        .rbank      (rbank),
        .prev_valid (prev_valid),
        .prev_data  (prev_data),
        .folw_valid (folw_valid),
        .folw_data  (folw_data),
        .host_valid (host_valid),
        .host_data  (host_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .wr_done    (wr_done),
        .err        (err)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mdl   [2][N];
    bit            known [2][N];
    bit            m_rbank, m_wr_done, m_err;
    exp_t          exp_q  [$];
    exp_t          pend_w [$];
    logic [DW-1:0] src_all [$];
    logic [DW-1:0] src_q  [$];
    route_cmd_t    src_sel = NOP;
    int            rdy_mode = 0;
    int            rdy_ph = 0;
    bit            self_chk = 0;
    bit            done_pend = 0;
    bit            held_v = 0;
    logic [DW-1:0] held_d;
    int            n_hs = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // out_ready driver: 0 = always, 1 = 1,0,0,1 pattern, 2 = random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            rdy_ph++;
        end
    end

    // source stream driver with random gaps
    initial begin
        logic [DW-1:0] w;
        prev_valid = 0; folw_valid = 0; host_valid = 0;
        prev_data = '0; folw_data = '0; host_data = '0;
        forever begin
            @(posedge clk); #1;
            prev_valid = 0; folw_valid = 0; host_valid = 0;
            if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                w = src_q.pop_front();
                case (src_sel)
                    PREV:    begin prev_valid = 1; prev_data = w; end
                    FOLW:    begin folw_valid = 1; folw_data = w; end
                    HOST:    begin host_valid = 1; host_data = w; end
                    default: ;
                endcase
            end
        end
    end

    // monitor: pops the scoreboard on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_pend) begin
                chk("done_after_last_hs", busy, 0);
                done_pend = 0;
            end
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_stable", out_data, held_d);
            end
            if (out_valid && out_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.care) chk("out_word", out_data, e.d);
                    if (exp_q.size() == 0 && self_chk) done_pend = 1;
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        cmd_valid = 0; swap = 0; opt_en = 0; cmd = NOP;
        src_q.delete(); exp_q.delete();
        held_v = 0; done_pend = 0; self_chk = 0;
        m_rbank = 0; m_wr_done = 0; m_err = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_idle_state(input string name);
        chk({name, "_cmd_ready"}, cmd_ready, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_rbank"}, rbank, m_rbank);
        chk({name, "_wr_done"}, wr_done, m_wr_done);
        chk({name, "_err"}, err, m_err);
    endtask

    task automatic swap_pulse(input string name);
        if (m_wr_done) begin
            m_rbank = !m_rbank;
            m_wr_done = 0;
        end else begin
            m_err = 1;
        end
        swap = 1;
        @(posedge clk); #1;
        swap = 0;
        @(negedge clk);
        chk({name, "_rbank"}, rbank, m_rbank);
        chk({name, "_wr_done"}, wr_done, m_wr_done);
        chk({name, "_err"}, err, m_err);
    endtask

    // pat: 0 random, 1 descending, 2 ascending; nsrc words queued now
    task automatic start_cmd(input route_cmd_t c, input bit oe, input int lo,
                             input int hi, input bit sw, input int pat,
                             input int nsrc);
        bit oe_eff;
        int a;
        logic [DW-1:0] w;
        if (sw) begin
            if (m_wr_done) begin
                m_rbank = !m_rbank;
            end else begin
                m_err = 1;
            end
        end
        if (oe && lo > hi) m_err = 1;
        oe_eff = oe && (lo <= hi);
        m_wr_done = 0;
        pend_w.delete();
        src_all.delete();
        for (int p = 0; p < N; p++) begin
            a = (oe_eff && p >= lo && p <= hi) ? lo + hi - p : p;
            exp_q.push_back('{d: mdl[m_rbank][a], care: known[m_rbank][a]});
            if (c == SELF)
                pend_w.push_back('{d: mdl[m_rbank][a], care: known[m_rbank][a]});
        end
        if (c != SELF) begin
            for (int i = 0; i < ((nsrc > N) ? nsrc : N); i++) begin
                if (i < N && pat == 1)      w = DW'(N - 1 - i);
                else if (i < N && pat == 2) w = DW'(i);
                else                        w = DW'($urandom);
                src_all.push_back(w);
                if (i < N) pend_w.push_back('{d: w, care: 1'b1});
            end
        end
        self_chk = (c == SELF);
        cmd = c; opt_en = oe; opt_lo = AW'(lo); opt_hi = AW'(hi);
        swap = sw; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0; swap = 0; opt_en = 0; cmd = NOP;
        src_sel = c;
        for (int i = 0; i < nsrc && i < src_all.size(); i++)
            src_q.push_back(src_all[i]);
        @(negedge clk);
        chk("cmd_ready_low", cmd_ready, 0);
        chk("rbank_at_start", rbank, m_rbank);
        @(negedge clk);
        chk("first_valid_early", out_valid, 0);
        @(negedge clk);
        chk("first_valid_at_2", out_valid, 1);
    endtask

    task automatic finish_cmd(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, (n < 400) ? 1 : 0, 1);
        chk({name, "_exp_left"}, exp_q.size(), 0);
        if (pend_w.size() == N) begin
            for (int i = 0; i < N; i++) begin
                mdl[!m_rbank][i]   = pend_w[i].d;
                known[!m_rbank][i] = pend_w[i].care;
            end
            m_wr_done = 1;
        end
        chk({name, "_wr_done"}, wr_done, m_wr_done);
        chk({name, "_rbank"}, rbank, m_rbank);
        chk({name, "_err"}, err, m_err);
        src_q.delete();
        self_chk = 0;
    endtask

    initial begin
        int base, lo, hi, k;
        route_cmd_t rc;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) begin
                known[b][i] = 0;
                mdl[b][i] = '0;
            end
        cmd = NOP; opt_lo = '0; opt_hi = '0;
        do_reset();
        chk_idle_state("reset");

        // host load 7..0 into bank 1, swap, then SELF streams it back
        start_cmd(HOST, 0, 0, 0, 0, 1, N);
        finish_cmd("host_load");
        swap_pulse("swap1");
        start_cmd(SELF, 0, 0, 0, 0, 0, 0);
        finish_cmd("self_plain");

        // bank 0 gets 0..7, then swap + FOLW with reversal 2..5
        start_cmd(HOST, 0, 0, 0, 0, 2, N);
        finish_cmd("host_asc");
        start_cmd(FOLW, 1, 2, 5, 1, 0, N + 2);
        finish_cmd("folw_rev");

        // SELF under 1,0,0,1 backpressure
        rdy_mode = 1; rdy_ph = 0;
        start_cmd(SELF, 0, 0, 0, 0, 0, 0);
        finish_cmd("self_stall");

        // partial PREV stream holds DRAIN until the last 3 words
        rdy_mode = 2;
        start_cmd(PREV, 0, 0, 0, 0, 0, 5);
        repeat (N + 12) @(negedge clk);
        chk("part_busy", busy, 1);
        chk("part_wr_done", wr_done, 0);
        for (int i = 5; i < N; i++) src_q.push_back(src_all[i]);
        finish_cmd("part_prev");

        // reset in the middle of a stream
        rdy_mode = 0;
        base = n_hs;
        start_cmd(PREV, 0, 0, 0, 0, 0, 0);
        k = 0;
        while (n_hs < base + 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reach3", (n_hs >= base + 3) ? 1 : 0, 1);
        chk("mid_busy", busy, 1);
        do_reset();
        chk_idle_state("mid_reset");
        start_cmd(PREV, 0, 0, 0, 0, 0, N);
        finish_cmd("after_reset");

        // command while busy plus swap while busy
        start_cmd(HOST, 0, 0, 0, 0, 0, N);
        cmd_valid = 1; cmd = PREV; swap = 1;
        m_err = 1;
        @(negedge clk);
        cmd_valid = 0; cmd = NOP; swap = 0;
        chk("busy_cmd_err", err, 1);
        chk("busy_cmd_rbank", rbank, m_rbank);
        finish_cmd("busy_cmd");

        // swap without a complete write bank
        do_reset();
        swap_pulse("bad_swap");

        // inverted reversal range runs unreversed and flags err
        do_reset();
        start_cmd(HOST, 1, 5, 2, 0, 0, N);
        finish_cmd("bad_opt");

        // randomized commands
        for (int it = 0; it < 8; it++) begin
            rdy_mode = $urandom_range(0, 2);
            rc = route_cmd_t'($urandom_range(1, 4));
            lo = $urandom_range(0, N - 1);
            hi = $urandom_range(lo, N - 1);
            start_cmd(rc, 1'($urandom_range(0, 1)), lo, hi,
                      1'($urandom_range(0, 1)), 0, N + $urandom_range(0, 3));
            finish_cmd("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
